// File: rtl/carbon_arch_pkg.sv
// -----------------------------------------------------------------------------
// carbon_arch_pkg
// Shared types and helpers for the CAI submission arbiter.
//   cai_arb_state_e : submit sequencing states (IDLE / SETUP / RING)
//   cai_rr_pick_t   : result of a round-robin search (hit flag + index)
//   cai_rr_next()   : first valid requester after the last grant, wrapping
// -----------------------------------------------------------------------------
package carbon_arch_pkg;

    localparam int unsigned CAI_ARB_MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RING  = 2'd2
    } cai_arb_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } cai_rr_pick_t;

    // Walks n_req slots starting just after 'last', wrapping at n_req-1,
    // and returns the first slot whose valid bit is set.
    function automatic cai_rr_pick_t cai_rr_next(input logic [15:0]  valid,
                                                input logic [3:0]   last,
                                                input int unsigned  n_req);
        cai_rr_pick_t pick;
        logic [3:0]   idx;
        pick = '0;
        idx  = last;
        for (int unsigned i = 0; i < CAI_ARB_MAX_REQ; i++) begin
            if (i < n_req) begin
                idx = (idx == 4'(n_req - 1)) ? 4'd0 : idx + 4'd1;
                if (!pick.hit && valid[idx]) begin
                    pick.hit = 1'b1;
                    pick.idx = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cai_owner_fifo.sv
// -----------------------------------------------------------------------------
// cai_owner_fifo
// Synchronous FIFO holding the requester index of every outstanding submit,
// oldest at the head. DEPTH must be a power of two so pointers wrap naturally.
// Push while full and pop while empty are ignored.
//   clk, rst_n   : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i       : write push_idx_i at the tail
//   pop_i        : drop the head entry
//   head_o       : index at the head (valid when !empty_o)
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : current occupancy
// -----------------------------------------------------------------------------
module cai_owner_fifo #(
    parameter int IDX_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [IDX_W-1:0]             push_idx_i,
    input  logic                         pop_i,
    output logic [IDX_W-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cai_submit_arb.sv
// -----------------------------------------------------------------------------
// cai_submit_arb
// Round-robin scheduler sharing one CAI host submit port among N_REQ
// requesters. One accepted request is presented on submit_* for a setup
// cycle, then rung with a single-cycle submit_doorbell. Owners of outstanding
// submits are queued so each comp_doorbell is routed back as done[owner].
//
// Optional feature macro: CARBON_CAI_ARB_TIMEOUT_EN
//   defined   : completion watchdog; timeout_err blocks grants until err_clr
//   undefined : no watchdog, timeout_err tied low, TIMEOUT_CYC unused
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester handshake; ready is one-hot, IDLE only
//   req_desc_base     : per-requester descriptor ring base
//   req_ring_mask     : per-requester ring mask
//   req_ctx           : per-requester context
//   submit_desc_base  : registered base to CAI
//   submit_ring_mask  : registered mask to CAI
//   context_sel       : registered context to CAI
//   submit_doorbell   : single-cycle ring pulse to CAI
//   comp_doorbell     : completion from CAI, one per high cycle
//   done              : one-hot completion pulse to the owning requester
//   outstanding       : owner-FIFO occupancy
//   spurious_err      : sticky, completion seen with nothing outstanding
//   timeout_err       : sticky, watchdog expiry
//   err_clr           : clears both sticky errors (a same-cycle set wins)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; req_ready may be asserted
// SETUP | submit fields stable, doorbell low
// RING  | submit_doorbell high for this cycle only
// -----------------------------------------------------------------------------
module cai_submit_arb
    import carbon_arch_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = 64,
    parameter int CTX_W       = 16,
    parameter int MAX_OUT     = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0][ADDR_W-1:0]      req_desc_base,
    input  logic [N_REQ-1:0][31:0]            req_ring_mask,
    input  logic [N_REQ-1:0][CTX_W-1:0]       req_ctx,
    output logic [ADDR_W-1:0]                 submit_desc_base,
    output logic [31:0]                       submit_ring_mask,
    output logic [CTX_W-1:0]                  context_sel,
    output logic                              submit_doorbell,
    input  logic                              comp_doorbell,
    output logic [N_REQ-1:0]                  done,
    output logic [$clog2(MAX_OUT+1)-1:0]      outstanding,
    output logic                              spurious_err,
    output logic                              timeout_err,
    input  logic                              err_clr
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("cai_submit_arb: N_REQ must be 2..16");
    end
    if (MAX_OUT < 2 || (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_bad_max_out
        $error("cai_submit_arb: MAX_OUT must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("cai_submit_arb: TIMEOUT_CYC must be >= 1");
    end

    cai_arb_state_e      state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         mask_q;
    logic [CTX_W-1:0]    ctx_q;
    logic                doorbell_q;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                spurious_q, spurious_d;

    cai_rr_pick_t        pick;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;
    logic                pop;
    logic                spurious_set;
    logic [IDX_W-1:0]    fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        pick = cai_rr_next(16'(req_valid), 4'(last_grant_q), N_REQ);
    end

    assign grant_idx = IDX_W'(pick.idx);
    assign accept    = (state_q == IDLE) && pick.hit && !fifo_full && !timeout_err;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------- owner FIFO
    assign pop          = comp_doorbell && !fifo_empty;
    assign spurious_set = comp_doorbell && fifo_empty;

    cai_owner_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (accept),
        .push_idx_i (grant_idx),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // -------------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = RING;
            RING:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d = '0;
        if (pop) begin
            done_d = N_REQ'(1) << fifo_head;
        end
    end

    always_comb begin
        spurious_d = spurious_q;
        if (spurious_set) begin
            spurious_d = 1'b1;
        end else if (err_clr) begin
            spurious_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            base_q       <= '0;
            mask_q       <= '0;
            ctx_q        <= '0;
            doorbell_q   <= 1'b0;
            done_q       <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            doorbell_q <= (state_d == RING);
            done_q     <= done_d;
            spurious_q <= spurious_d;
            // Fields only move on accept, which cannot happen in SETUP/RING,
            // so they are stable across the doorbell.
            if (accept) begin
                last_grant_q <= grant_idx;
                base_q       <= req_desc_base[grant_idx];
                mask_q       <= req_ring_mask[grant_idx];
                ctx_q        <= req_ctx[grant_idx];
            end
        end
    end

    // --------------------------------------------------------------- watchdog
`ifdef CARBON_CAI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_reload;
    logic             tmo_expire;
    logic             timeout_q, timeout_d;

    // Down-counter re-armed on every pop and on the first push into an empty
    // FIFO; expiry is the step from 1 to 0 while anything is outstanding.
    assign tmo_reload = pop || (accept && fifo_empty);
    assign tmo_expire = !tmo_reload && (fifo_count != '0) && (tmo_cnt_q == TMO_W'(1));

    always_comb begin
        timeout_d = timeout_q;
        if (tmo_expire) begin
            timeout_d = 1'b1;
        end else if (err_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (tmo_reload) begin
                tmo_cnt_q <= TMO_W'(TIMEOUT_CYC);
            end else if (fifo_count != '0 && tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // ---------------------------------------------------------------- outputs
    assign submit_desc_base = base_q;
    assign submit_ring_mask = mask_q;
    assign context_sel      = ctx_q;
    assign submit_doorbell  = doorbell_q;
    assign done             = done_q;
    assign outstanding      = fifo_count;
    assign spurious_err     = spurious_q;

endmodule
